pool_window_buffer: RTL
=======================

// Module: pool_window_buffer
// PURPOSE
//  Upstream feeder for the max-pool comparator tree. Accepts a raster-order stream of 32-bit
//  feature-map pixels, buffers one band of WINDOW_SIZE rows, then emits non-overlapping
//  WINDOW_SIZE x WINDOW_SIZE windows (stride = WINDOW_SIZE), packed for direct connection to
//  the pool input bus. Single buffer: fill and drain alternate, no overlap.
// PARAMETERS
//  WINDOW_SIZE  4   window edge and stride; pool fan-in is WINDOW_SIZE*WINDOW_SIZE
//  IMG_WIDTH    16  pixels per row; must be an integer multiple of WINDOW_SIZE
//  IMG_HEIGHT   16  rows per frame; must be an integer multiple of WINDOW_SIZE
//  DATA_WIDTH   32  pixel width (IEEE-754 single in this datapath; block does no arithmetic on it)
// PORTS
//  clk        in   1                                  rising-edge clock
//  reset      in   1                                  asynchronous, active-high reset
//  in_valid   in   1                                  in_data valid
//  in_ready   out  1                                  buffer accepts pixel this cycle
//  in_data    in   DATA_WIDTH                         pixel, raster order (row-major, top-left first)
//  win_valid  out  1                                  win_data holds a complete window
//  win_ready  in   1                                  downstream consumes window this cycle
//  win_data   out  [WINDOW_SIZE*WINDOW_SIZE-1:0][DATA_WIDTH-1:0]  element r*WINDOW_SIZE+c = pixel (r,c) of window
//  win_col    out  $clog2(IMG_WIDTH/WINDOW_SIZE)       window column index within the current band
//  win_last   out  1                                  qualifies last window of frame (with win_valid)
// BEHAVIOUR
//  - Reset (async assert, sync release): state FILL, col/row/window counters 0, in_ready=1,
//    win_valid=0, win_col=0, win_last=0, win_data=0. Buffer RAM contents don't care.
//  - Transfer rules: input beat when in_valid&in_ready; output beat when win_valid&win_ready.
//    win_valid, once high, stays high with win_data/win_col/win_last stable until the beat.
//  - FILL: in_ready=1, win_valid=0. Each input beat writes buffer[row_in_band][col]; col wraps at
//    IMG_WIDTH-1 to 0 and increments row_in_band. Beat writing (WINDOW_SIZE-1, IMG_WIDTH-1)
//    moves to DRAIN; win_valid rises the next cycle (latency 1 from last band pixel to win_valid).
//  - DRAIN: in_ready=0. Window k (k=0..IMG_WIDTH/WINDOW_SIZE-1) presents columns
//    k*WINDOW_SIZE..k*WINDOW_SIZE+WINDOW_SIZE-1 of all WINDOW_SIZE buffered rows; win_col=k.
//    Each output beat advances k; back-to-back windows with win_ready held high (one per cycle).
//    Beat on last k returns to FILL with in_ready=1 the next cycle; band counter increments.
//  - win_last=1 only for the final window of band IMG_HEIGHT/WINDOW_SIZE-1; band counter wraps to
//    0 after that beat, next input pixel is treated as (0,0) of a new frame.
//  - win_ready low in DRAIN: hold indefinitely; no input accepted, no data lost.
//  - in_valid ignored in DRAIN (in_ready=0); upstream must hold its pixel.
//  - win_ready high while win_valid=0: no effect.
//  - reset mid-band or mid-drain: partial band discarded, all outputs to reset values immediately.
//  - Throughput: IMG_WIDTH*WINDOW_SIZE fill cycles + IMG_WIDTH/WINDOW_SIZE drain cycles per band.
// TESTING (WINDOW_SIZE=2, IMG_WIDTH=4, IMG_HEIGHT=4, pixel(r,c)=r*4+c unless noted)
//  1 Reset then stream 8 pixels with in_valid=1, win_ready=1 -> in_ready drops after 8th beat;
//    next cycle win_valid=1, win_data={0,1,4,5}, win_col=0; following cycle {2,3,6,7}, win_col=1.
//  2 Full frame, 16 pixels, win_ready=1 -> 4 windows {0,1,4,5},{2,3,6,7},{8,9,12,13},
//    {10,11,14,15}; win_last=1 only on the 4th; in_ready=1 the cycle after.
//  3 In DRAIN hold win_ready=0 for 10 cycles -> win_valid stays 1, win_data {0,1,4,5} stable,
//    in_ready=0 throughout; release -> both windows delivered in order.
//  4 Random in_valid gaps (~50%) and random win_ready -> windows identical to scenario 2;
//    no beat duplicated or dropped.
//  5 Assert reset after 5 pixels, then stream a fresh frame -> first window {0,1,4,5} of new
//    frame; none of the 5 stale pixels appear.
//  6 Two consecutive frames, frame 2 pixel = 100+r*4+c -> frame 2 first window {100,101,104,105},
//    win_col=0; win_last once per frame.

Source files
------------

// File: rtl/pool_window_buffer.sv
// pool_window_buffer: buffers one band of WINDOW_SIZE raster rows, then emits
// non-overlapping WINDOW_SIZE x WINDOW_SIZE windows left to right, one window
// per output beat. Fill and drain alternate on a single band buffer.
module pool_window_buffer #(
   parameter int WINDOW_SIZE = 4,
   parameter int IMG_WIDTH   = 16,
   parameter int IMG_HEIGHT  = 16,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic                                                 in_valid,
   output logic                                                 in_ready,
   input  logic [DATA_WIDTH-1:0]                                in_data,
   output logic                                                 win_valid,
   input  logic                                                 win_ready,
   output logic [WINDOW_SIZE*WINDOW_SIZE-1:0][DATA_WIDTH-1:0]   win_data,
   output logic [$clog2(IMG_WIDTH/WINDOW_SIZE)-1:0]             win_col,
   output logic                                                 win_last
);

   localparam int NUM_COLS  = IMG_WIDTH / WINDOW_SIZE;
   localparam int NUM_BANDS = IMG_HEIGHT / WINDOW_SIZE;
   localparam int COL_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int ROW_W     = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
   localparam int BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam int WCOL_W    = $clog2(NUM_COLS);

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t               state;
   logic [COL_W-1:0]     col;
   logic [ROW_W-1:0]     row;
   logic [BAND_W-1:0]    band;

   // Band buffer: data only, never reset; contents are meaningless until written.
   logic [DATA_WIDTH-1:0] buffer [0:WINDOW_SIZE-1][0:IMG_WIDTH-1];

   logic                 wr_en;
   logic                 last_col;
   logic                 last_row;
   logic                 last_band;
   logic                 last_win;
   logic [COL_W-1:0]     col_base;

   assign wr_en     = in_valid & in_ready;
   assign last_col  = (col == COL_W'(IMG_WIDTH - 1));
   assign last_row  = (row == ROW_W'(WINDOW_SIZE - 1));
   assign last_band = (band == BAND_W'(NUM_BANDS - 1));
   assign last_win  = (win_col == WCOL_W'(NUM_COLS - 1));

   // Leftmost buffer column of the window currently presented.
   assign col_base  = COL_W'(win_col) * COL_W'(WINDOW_SIZE);

   // Control FSM: fill counters, drain window index and all handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FILL;
         col       <= '0;
         row       <= '0;
         band      <= '0;
         in_ready  <= 1'b1;
         win_valid <= 1'b0;
         win_col   <= '0;
         win_last  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (in_valid) begin
                  if (last_col) begin
                     col <= '0;
                     if (last_row) begin
                        // Band complete: present window 0 on the next cycle.
                        row       <= '0;
                        state     <= DRAIN;
                        in_ready  <= 1'b0;
                        win_valid <= 1'b1;
                        win_col   <= '0;
                        win_last  <= last_band && (NUM_COLS == 1);
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (win_ready) begin
                  if (last_win) begin
                     state     <= FILL;
                     in_ready  <= 1'b1;
                     win_valid <= 1'b0;
                     win_col   <= '0;
                     win_last  <= 1'b0;
                     band      <= last_band ? '0 : band + 1'b1;
                  end else begin
                     win_col  <= win_col + 1'b1;
                     win_last <= last_band && (win_col == WCOL_W'(NUM_COLS - 2));
                  end
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

   // Band buffer write: one pixel per accepted input beat at (row, col).
   always_ff @(posedge clk) begin
      if (wr_en) begin
         buffer[row][col] <= in_data;
      end
   end

   // Window read mux; forced to zero while no window is presented so the
   // output bus matches its reset value.
   for (genvar r = 0; r < WINDOW_SIZE; r++) begin : g_row
      for (genvar c = 0; c < WINDOW_SIZE; c++) begin : g_col
         assign win_data[r*WINDOW_SIZE + c] =
            win_valid ? buffer[r][col_base + COL_W'(c)] : '0;
      end
   end

endmodule
